// File: rtl/des_key_schedule_enc.sv
// des_key_schedule_enc: sequential DES encryption key schedule, one PC-2 subkey per accepted beat
module des_key_schedule_enc #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key_in,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic [3:0]  subkey_round,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, LOAD, GEN} state_t;

    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    // rounds 0, 1, 8 and 15 rotate by one; all others by two
    localparam logic [15:0] ONE_SHIFT = 16'b1000_0001_0000_0011;

    state_t      state;
    logic [27:0] c, d, c_n, d_n;
    logic [3:0]  nr;
    logic [55:0] key_cd;

    // DES bit n lives at vector index 64-n (key) / 56-n (C||D)
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    // next-round rotation of C/D; LOAD always produces round 0
    always_comb begin
        key_cd = pc1(key_in);
        nr     = (state == LOAD) ? 4'd0 : subkey_round + 4'd1;
        c_n    = rotl(c, ONE_SHIFT[nr]);
        d_n    = rotl(d, ONE_SHIFT[nr]);
    end

    // control FSM with registered handshake outputs and C/D state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            key_ready    <= 1'b1;
            subkey_valid <= 1'b0;
            subkey       <= '0;
            subkey_round <= '0;
            busy         <= 1'b0;
            c            <= '0;
            d            <= '0;
        end else begin
            case (state)
                IDLE: if (key_valid) begin
                    c            <= key_cd[55:28];
                    d            <= key_cd[27:0];
                    subkey_round <= '0;
                    key_ready    <= 1'b0;
                    state        <= LOAD;
                end
                LOAD: begin
                    c            <= c_n;
                    d            <= d_n;
                    subkey       <= pc2({c_n, d_n});
                    subkey_round <= '0;
                    subkey_valid <= 1'b1;
                    busy         <= 1'b1;
                    state        <= GEN;
                end
                GEN: if (subkey_ready) begin
                    if (subkey_round == 4'(NUM_ROUNDS - 1)) begin
                        subkey_valid <= 1'b0;
                        busy         <= 1'b0;
                        key_ready    <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        c            <= c_n;
                        d            <= d_n;
                        subkey       <= pc2({c_n, d_n});
                        subkey_round <= nr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_stable: assert property (@(posedge clk) disable iff (!rst_n)
        subkey_valid && !subkey_ready |=> $stable(subkey) && $stable(subkey_round));
endmodule

// File: tb/tb_des_key_schedule_enc.sv
// tb_des_key_schedule_enc: directed checks of the DES encryption key schedule
module tb_des_key_schedule_enc;
    logic        clk = 1'b0;
    logic        rst_n, key_valid, key_ready, subkey_valid, subkey_ready, busy;
    logic [63:0] key_in;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    int          checks = 0;
    int          passed = 0;

    localparam logic [63:0] FIPS_KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] OTHER_KEY = 64'h0F1571C947D9E859;
    localparam logic [47:0] OTHER_K1  = 48'h7833C320DA70;
    localparam logic [47:0] FIPS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    always #5 clk = ~clk;

    des_key_schedule_enc #(.NUM_ROUNDS(16)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
        .key_in(key_in), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
        .subkey(subkey), .subkey_round(subkey_round), .busy(busy)
    );

    task automatic send_key(input logic [63:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_in    = k;
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; key_valid = 1'b0; subkey_ready = 1'b0; key_in = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (key_ready !== 1'b1) $display("FAIL reset_key_ready got %b want 1", key_ready); else passed++;
        checks++; if (subkey_valid !== 1'b0) $display("FAIL reset_subkey_valid got %b want 0", subkey_valid); else passed++;
        checks++; if (subkey !== 48'h0) $display("FAIL reset_subkey got %h want 0", subkey); else passed++;
        checks++; if (subkey_round !== 4'd0) $display("FAIL reset_round got %0d want 0", subkey_round); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fips;
        subkey_ready = 1'b1;
        send_key(FIPS_KEY);
        @(negedge clk);
        checks++; if (subkey_valid !== 1'b0) $display("FAIL fips_load_valid got %b want 0", subkey_valid); else passed++;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (subkey_valid !== 1'b1 || subkey_round !== 4'(i) || subkey !== FIPS[i] || busy !== 1'b1)
                $display("FAIL fips_beat%0d got v=%b r=%0d k=%h busy=%b want v=1 r=%0d k=%h busy=1",
                         i, subkey_valid, subkey_round, subkey, busy, i, FIPS[i]);
            else passed++;
        end
        @(negedge clk);
        checks++;
        if (subkey_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL fips_end got v=%b kr=%b busy=%b want v=0 kr=1 busy=0", subkey_valid, key_ready, busy);
        else passed++;
    endtask

    task automatic test_backpressure;
        int beats = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [47:0] prev_k = '0;
        logic [3:0] prev_r = '0;
        subkey_ready = 1'b0;
        send_key(FIPS_KEY);
        while (beats < 16 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                checks++;
                if (subkey_valid !== 1'b1 || subkey !== prev_k || subkey_round !== prev_r)
                    $display("FAIL bp_stable got v=%b r=%0d k=%h want v=1 r=%0d k=%h",
                             subkey_valid, subkey_round, subkey, prev_r, prev_k);
                else passed++;
            end
            subkey_ready = 1'($urandom_range(0, 1));
            if (subkey_valid && subkey_ready) begin
                checks++;
                if (subkey_round !== 4'(beats) || subkey !== FIPS[beats])
                    $display("FAIL bp_beat%0d got r=%0d k=%h want r=%0d k=%h",
                             beats, subkey_round, subkey, beats, FIPS[beats]);
                else passed++;
                beats++;
            end
            stalled = subkey_valid && !subkey_ready;
            prev_k  = subkey;
            prev_r  = subkey_round;
        end
        checks++; if (beats != 16) $display("FAIL bp_beat_count got %0d want 16", beats); else passed++;
        @(negedge clk);
        subkey_ready = 1'b1;
        checks++;
        if (subkey_valid !== 1'b0 || key_ready !== 1'b1)
            $display("FAIL bp_end got v=%b kr=%b want v=0 kr=1", subkey_valid, key_ready);
        else passed++;
    endtask

    task automatic test_parity;
        logic [63:0] keys [2] = '{64'h123456789ABCDEF0, 64'h133557799BBDDFF1};
        subkey_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            send_key(keys[k]);
            @(negedge clk);
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                checks++;
                if (subkey_valid !== 1'b1 || subkey_round !== 4'(i) || subkey !== FIPS[i])
                    $display("FAIL parity_key%0d_beat%0d got v=%b r=%0d k=%h want v=1 r=%0d k=%h",
                             k, i, subkey_valid, subkey_round, subkey, i, FIPS[i]);
                else passed++;
            end
            @(negedge clk);
            checks++;
            if (dut.c !== 28'hF0CCAAF || dut.d !== 28'h556678F)
                $display("FAIL parity_cd_wrap%0d got c=%h d=%h want c=f0ccaaf d=556678f", k, dut.c, dut.d);
            else passed++;
        end
    endtask

    task automatic test_key_during_gen;
        subkey_ready = 1'b1;
        send_key(FIPS_KEY);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            key_valid = (i == 7 || i == 15);
            key_in    = OTHER_KEY;
            checks++;
            if (subkey_valid !== 1'b1 || subkey_round !== 4'(i) || subkey !== FIPS[i])
                $display("FAIL kdg_beat%0d got v=%b r=%0d k=%h want v=1 r=%0d k=%h",
                         i, subkey_valid, subkey_round, subkey, i, FIPS[i]);
            else passed++;
        end
        @(negedge clk);
        checks++;
        if (subkey_valid !== 1'b0 || key_ready !== 1'b1)
            $display("FAIL kdg_not_taken got v=%b kr=%b want v=0 kr=1", subkey_valid, key_ready);
        else passed++;
        @(posedge clk);
        #1 key_valid = 1'b0;
        @(negedge clk);
        checks++; if (key_ready !== 1'b0) $display("FAIL kdg_accept got kr=%b want 0", key_ready); else passed++;
        @(negedge clk);
        checks++;
        if (subkey_valid !== 1'b1 || subkey_round !== 4'd0 || subkey !== OTHER_K1)
            $display("FAIL kdg_restart got v=%b r=%0d k=%h want v=1 r=0 k=%h", subkey_valid, subkey_round, subkey, OTHER_K1);
        else passed++;
        repeat (16) @(negedge clk);
        checks++; if (key_ready !== 1'b1) $display("FAIL kdg_drain got kr=%b want 1", key_ready); else passed++;
    endtask

    task automatic test_reset_mid;
        subkey_ready = 1'b1;
        send_key(FIPS_KEY);
        @(negedge clk);
        repeat (10) @(negedge clk);
        checks++; if (subkey_round !== 4'd9) $display("FAIL rmid_at9 got r=%0d want 9", subkey_round); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (subkey_valid !== 1'b0 || busy !== 1'b0 || subkey !== 48'h0 || key_ready !== 1'b1)
            $display("FAIL rmid_async got v=%b busy=%b k=%h kr=%b want v=0 busy=0 k=0 kr=1",
                     subkey_valid, busy, subkey, key_ready);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (subkey_valid !== 1'b0 || key_ready !== 1'b1)
            $display("FAIL rmid_release got v=%b kr=%b want v=0 kr=1", subkey_valid, key_ready);
        else passed++;
        send_key(OTHER_KEY);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (subkey_valid !== 1'b1 || subkey_round !== 4'd0 || subkey !== OTHER_K1)
            $display("FAIL rmid_newkey got v=%b r=%0d k=%h want v=1 r=0 k=%h", subkey_valid, subkey_round, subkey, OTHER_K1);
        else passed++;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_fips;
        test_backpressure;
        test_parity;
        test_key_during_gen;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/des_key_schedule_enc.md
Name: des_key_schedule_enc

Overview:
Sequential DES encryption key-schedule generator. It takes a 64-bit key, applies PC-1, then left-rotates C/D once per round using the encryption shift schedule. Each round it applies PC-2 and emits one 48-bit subkey, K1 through K16, over a valid/ready stream. It is the encryption-direction counterpart of the decryption right-rotate path and feeds the round datapath one subkey per accepted beat.

Parameters:
- NUM_ROUNDS, 16, number of subkeys produced per key. Fixed at 16 for DES; a bench may check it.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- key_valid, input, 1, key_in is valid.
- key_ready, output, 1, block can accept a new key.
- key_in, input, 64, DES key; key_in[63] = DES bit 1, key_in[0] = DES bit 64. Parity bits are ignored.
- subkey_valid, output, 1, subkey and subkey_round are valid.
- subkey_ready, input, 1, consumer accepts the current subkey.
- subkey, output, 48, PC-2 output; subkey[47] = PC-2 bit 1.
- subkey_round, output, 4, index 0..15 of the current subkey (0 = K1).
- busy, output, 1, high while in GEN.

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-low.
- Reset values:
  - State = IDLE.
  - key_ready=1, subkey_valid=0, subkey=0, subkey_round=0, busy=0.
  - C/D registers = 0; round counter = 0.
- State IDLE:
  - key_ready=1.
  - On key_valid&&key_ready: register C = PC-1 left half, D = PC-1 right half, counter = 0, go to LOAD.
- State LOAD (1 cycle):
  - key_ready=0. Compute C' = C <<< shift(0) and D' = D <<< shift(0).
  - Register subkey = PC-2({C',D'}), subkey_round = 0, subkey_valid = 1. Store C', D'. Go to GEN.
- State GEN:
  - subkey_valid held high; subkey and subkey_round stable while !subkey_ready.
  - On subkey_valid&&subkey_ready with counter < 15:
    - counter++.
    - C/D rotate left by shift(counter+1).
    - Next subkey is registered in the same edge.
    - subkey_valid stays 1, giving back-to-back beats with no bubble.
  - On subkey_valid&&subkey_ready with counter == 15: subkey_valid=0, go to IDLE. key_ready=1 on the next cycle.
- Shift schedule (rounds 0..15): 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. The total is 28, so C/D return to the PC-1 value after K16.
- Rotation: 28-bit circular left shift. The MSB (C[27]) wraps to C[0]; the same rule applies to D.
- Latency: key accept edge → first subkey_valid after 2 clock edges. With subkey_ready held at 1, all 16 subkeys take 17 cycles from accept.
- Key handshake: key_valid while key_ready=0 is ignored. There is no queueing; a new key is only taken in IDLE.
- subkey_ready while subkey_valid=0: no effect.
- Simultaneous final-beat accept and key_valid in the same cycle: the key is NOT taken, because key_ready is 0 in GEN. It is accepted the following cycle.
- Reset mid-generation: all state is cleared immediately (asynchronously). No partial subkey is emitted after rst_n rises.
- PC-1 and PC-2 tables follow FIPS 46-3 exactly. The permutations are pure wiring; only C, D, the counter, the state and the output registers are flops.
- Optional assertions:
  - unique state encoding;
  - subkey_round ≤ 15 whenever subkey_valid is high;
  - subkey stable while subkey_valid && !subkey_ready.

Test Plan:
1. Reset: assert rst_n=0 mid-clock. Required: key_ready=1, subkey_valid=0, subkey=0 immediately, before any clock edge.
2. FIPS key 133457799BBCDFF1 with subkey_ready tied 1. Required:
   - subkey_round 0 gives subkey=1B02EFFC7072.
   - subkey_round 15 gives subkey=CB3D8B0E17F5.
   - Exactly 16 beats, contiguous, first beat 2 cycles after the accept edge.
3. Backpressure: same key, subkey_ready toggled randomly. Required: the sequence is identical to scenario 2, and subkey/subkey_round are stable while stalled.
4. Parity invariance: key 123456789ABCDEF0 and the same key with every LSB of each byte flipped (133457799BBCDFF1-style parity change). Required: identical 16-subkey sequences. Also check internal C/D after K16 equals the PC-1 value (28-rotation wrap).
5. Key during GEN: pulse key_valid=1 with key 0F1571C947D9E859 at round 7. Required: it is ignored and the current sequence completes unchanged. Re-presenting it after subkey_round 15 is accepted, and it restarts at round 0.
6. Reset at subkey_round 9: deassert rst_n. Required: subkey_valid drops at once. After release, key_ready=1 and a new key gives the correct K1 with no residue.
